// File: rtl/fetch_prefetch.sv
// ---------------------------------------------------------------------------
// fetch_prefetch
//
// Instruction prefetch controller for the fetch stage. It walks a
// combinational, byte-addressed instruction ROM one 32-bit word per cycle.
// Each fetched word is buffered together with its PC in a small FIFO, and
// decode drains the FIFO through a valid/ready handshake. A redirect (branch,
// jump or trap) flushes the FIFO and restarts fetching at the new PC.
//
// Parameters:
//   ADDRESS_WIDTH  width of the PC and the ROM address
//   DEPTH          FIFO entries (power of two, >= 2)
//   RESET_PC       first fetch address after reset (bits [1:0] forced to 0)
//
// Ports:
//   clk             clock; all state changes on the rising edge
//   rst_n           synchronous active-low reset
//   redirect_valid  flush the FIFO and restart fetch this cycle
//   redirect_pc     restart address; bits [1:0] are ignored
//   mem_addr        ROM address; always equals the fetch_pc register
//   mem_rdata       ROM word for mem_addr, available in the same cycle
//   out_valid       head entry is available to decode
//   out_instr       head instruction
//   out_pc          PC of the head instruction
//   out_ready       decode accepts the head entry this cycle
//   level           current FIFO occupancy
// ---------------------------------------------------------------------------
module fetch_prefetch #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]      redirect_pc,
    output logic [ADDRESS_WIDTH-1:0]      mem_addr,
    input  logic [31:0]                   mem_rdata,
    output logic                          out_valid,
    output logic [31:0]                   out_instr,
    output logic [ADDRESS_WIDTH-1:0]      out_pc,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH):0]        level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    localparam logic [LEVEL_W-1:0]       DEPTH_L    = LEVEL_W'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] RESET_WORD = {RESET_PC[ADDRESS_WIDTH-1:2], 2'b00};

    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
    logic [31:0]              instr_mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [LEVEL_W-1:0]       count;
    logic                     pop;
    logic                     push;

    // The low two bits of a redirect target are dropped (word alignment).
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign mem_addr  = fetch_pc;
    assign level     = count;
    assign out_valid = (count != '0) & ~redirect_valid;
    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a new word when decode is draining it. A redirect blocks both.
    assign pop  = out_valid & out_ready & ~redirect_valid;
    assign push = ~redirect_valid & ((count < DEPTH_L) | pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_WORD;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= fetch_pc;
                instr_mem[wr_ptr] <= mem_rdata;
                wr_ptr            <= wr_ptr + PTR_W'(1);
                fetch_pc          <= fetch_pc + ADDRESS_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + LEVEL_W'(1);
            end else if (pop && !push) begin
                count <= count - LEVEL_W'(1);
            end
        end
    end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Instruction prefetch controller for the fetch stage. It sequences the combinational byte-addressed instruction ROM one 32-bit word per cycle. Fetched words and their PCs are buffered in a small FIFO, and each word is handed to decode through a valid/ready handshake. A redirect (branch, jump or trap) flushes the buffer and restarts fetching at the new PC.

## Interface

Parameters:
- ADDRESS_WIDTH, 32, width of PC and ROM address
- DEPTH, 4, FIFO entries; power of two, >= 2
- RESET_PC, 32'h00000000, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- redirect_valid  in  1  flush and restart fetch this cycle
- redirect_pc  in  ADDRESS_WIDTH  restart address; bits [1:0] ignored
- mem_addr  out  ADDRESS_WIDTH  address to instruction ROM; equals fetch_pc register
- mem_rdata  in  32  ROM word for mem_addr, same cycle (combinational ROM)
- out_valid  out  1  head entry available to decode
- out_instr  out  32  head instruction
- out_pc  out  ADDRESS_WIDTH  PC of head instruction
- out_ready  in  1  decode accepts head this cycle
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation

- State: fetch_pc register, DEPTH-entry storage of {pc, instr}, write and read pointers of $clog2(DEPTH) bits, occupancy counter.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~redirect_valid & (level < DEPTH | pop). When push is high, mem_rdata and fetch_pc are written at the write pointer, and fetch_pc advances by 4.
- Push and pop in the same cycle: level unchanged, both pointers advance. This is legal when full.
- Full with no pop: no push, fetch_pc holds, mem_addr stays stable.
- Empty: out_valid = 0; out_ready is ignored.
- out_valid = (level != 0) & ~redirect_valid.
- out_instr and out_pc come from storage at the read pointer. They are not bypassed from mem_rdata.
- Redirect takes priority over everything:
  - level, write pointer and read pointer go to 0.
  - fetch_pc is loaded with {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}.
  - No push and no pop occur that cycle.
- Wrap-around:
  - fetch_pc + 4 wraps modulo 2^ADDRESS_WIDTH.
  - Pointers wrap modulo DEPTH.
  - No range check against ROM size.
- Reset (rst_n low at an edge, including mid-stream):
  - fetch_pc = RESET_PC with bits [1:0] forced 0.
  - level = 0, pointers = 0, all storage = 0.
  - Therefore out_valid = 0, out_instr = 0, out_pc = 0, mem_addr = RESET_PC, level = 0.
- Reset has priority over redirect.

## Timing

- Fetch latency: a word pushed at edge N appears at the FIFO head, with out_valid high, in cycle N+1 if the FIFO was empty.
- After reset release: cycle 0 pushes RESET_PC, and cycle 1 presents out_pc = RESET_PC with out_valid = 1.
- Redirect penalty:
  - Cycle R (redirect high): out_valid = 0.
  - Cycle R+1: first push from the new PC, out_valid = 0.
  - Cycle R+2: out_valid = 1 with out_pc = new PC.
- Steady state with out_ready held high: one instruction per cycle, consecutive PCs, no bubbles.
- Backpressure: with out_ready low, the FIFO fills in DEPTH cycles and then holds. When out_ready rises, throughput is one per cycle immediately, since push-on-pop is allowed when full.
- mem_addr changes only at clock edges. The ROM read must settle within one cycle.

## Test plan

- Reset, then out_ready = 1 for 8 cycles with ROM word k = 32'h1000_0000+k: out_pc 0,4,8,…,28 on consecutive cycles from cycle 1; out_instr matches; level stays at 1.
- out_ready = 0 for 10 cycles: level reaches 4 after 4 pushes, mem_addr holds at 16. Then out_ready = 1: PCs 0,4,8,12,16,20 with no gap, level stays 4.
- Redirect to 32'h0000_0103 while FIFO is full:
  - out_valid = 0 in the redirect cycle and the following cycle.
  - Next out_pc = 32'h0000_0100.
  - No pre-redirect entries appear afterwards.
- Redirect asserted together with out_ready = 1 and out_valid = 1: no pop is counted, and the head entry is discarded.
- rst_n driven low for one cycle mid-stream with level = 3: the next cycle shows level = 0, out_valid = 0, out_instr = 0, mem_addr = RESET_PC.
- Redirect to 32'hFFFF_FFFC with ADDRESS_WIDTH = 32: emitted PCs are FFFF_FFFC, 0000_0000, 0000_0004 (wrap).
